// File: rtl/ps2_write.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_write
//  Purpose  : Host-to-device PS/2 command writer. Inhibits the bus, issues a
//             request-to-send, shifts one command byte (LSB first), odd parity
//             and stop bit on the device-generated clock, then checks the
//             device acknowledge and waits for the bus to go idle.
//  Ports    : qzt_clk   in   system clock, rising edge
//             reset_n   in   asynchronous active-low reset
//             start     in   one-cycle transmit request (honoured in IDLE only)
//             data_in   in   [7:0] command byte
//             PS2C      in   sensed PS/2 clock line
//             PS2D      in   sensed PS/2 data line
//             PS2C_low  out  1 = pull PS/2 clock low (open-drain enable)
//             PS2D_low  out  1 = pull PS/2 data low (open-drain enable)
//             busy      out  high whenever not idle
//             done      out  one-cycle pulse, byte sent and acknowledged
//             err       out  one-cycle pulse, no acknowledge or timeout
//  Revision : 1.0  initial release
// ============================================================================
module ps2_write #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       qzt_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       PS2C_low,
  output logic       PS2D_low,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One counter serves both the inhibit interval and the edge timeout,
  // so it is sized for the larger of the two.
  localparam int C_CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
  localparam logic [C_CNT_W-1:0] C_INH_LAST = C_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] C_TO_LAST  = C_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INHIBIT = 3'd1,
    S_REQ     = 3'd2,
    S_SEND    = 3'd3,
    S_ACK     = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
  logic                 ps2d_meta_q, ps2d_sync_q;
  logic [9:0]           shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 c_low_q, c_low_d;
  logic                 d_low_q, d_low_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 w_ps2c_fall;
  logic [C_CNT_W-1:0]   w_cnt_inc;

  assign w_ps2c_fall = ps2c_prev_q & ~ps2c_sync_q;
  assign w_cnt_inc   = cnt_q + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    c_low_d   = c_low_q;
    d_low_d   = d_low_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        c_low_d = 1'b0;
        d_low_d = 1'b0;
        if (start) begin
          // Frame bits after the start bit: data LSB first, odd parity, stop.
          shift_d   = {1'b1, ~^data_in, data_in};
          bit_cnt_d = 4'd0;
          cnt_d     = '0;
          c_low_d   = 1'b1;
          // A one-cycle inhibit has its last cycle right away.
          d_low_d   = (INHIBIT_CYCLES == 1);
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == C_INH_LAST) begin
          c_low_d = 1'b0;
          d_low_d = 1'b1;        // start bit, held through REQ
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = w_cnt_inc;
          // Data goes low so that it is visible in the final inhibit cycle.
          if (w_cnt_inc == C_INH_LAST) d_low_d = 1'b1;
        end
      end

      S_REQ, S_SEND, S_ACK, S_RELEASE: begin
        cnt_d = w_ps2c_fall ? '0 : w_cnt_inc;
        if (cnt_q == C_TO_LAST) begin
          c_low_d = 1'b0;
          d_low_d = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          case (state_q)
            S_REQ: begin
              if (w_ps2c_fall) begin
                d_low_d   = ~shift_q[0];
                shift_d   = {1'b0, shift_q[9:1]};
                bit_cnt_d = 4'd1;
                state_d   = S_SEND;
              end
            end
            S_SEND: begin
              if (w_ps2c_fall) begin
                d_low_d   = ~shift_q[0];
                shift_d   = {1'b0, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                // Index 9 is the stop bit; the next edge carries the ACK.
                if (bit_cnt_q == 4'd9) state_d = S_ACK;
              end
            end
            S_ACK: begin
              if (w_ps2c_fall) begin
                if (!ps2d_sync_q) begin
                  state_d = S_RELEASE;
                end else begin
                  c_low_d = 1'b0;
                  d_low_d = 1'b0;
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end
              end
            end
            S_RELEASE: begin
              if (ps2c_sync_q && ps2d_sync_q) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
            default: begin
            end
          endcase
        end
      end

      default: begin
        c_low_d = 1'b0;
        d_low_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers: synchronizers, FSM, counters and all outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge qzt_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2c_prev_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= 4'd0;
      cnt_q       <= '0;
      c_low_q     <= 1'b0;
      d_low_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps2c_meta_q <= PS2C;
      ps2c_sync_q <= ps2c_meta_q;
      ps2c_prev_q <= ps2c_sync_q;
      ps2d_meta_q <= PS2D;
      ps2d_sync_q <= ps2d_meta_q;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      cnt_q       <= cnt_d;
      c_low_q     <= c_low_d;
      d_low_q     <= d_low_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign PS2C_low = c_low_q;
  assign PS2D_low = d_low_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule
`default_nettype wire
